// File: rtl/id_emitter_pkg.sv
// Shared definitions for the identifier path: FSM encoding, ASCII constants
// and the letter/digit class bounds that the recognizer also checks.
package id_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LET  = 2'd1,
    S_DIG  = 2'd2,
    S_TERM = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_UA = 8'd65;
  localparam logic [7:0] ASCII_LA = 8'd97;
  localparam logic [7:0] ASCII_0  = 8'd48;
  localparam logic [7:0] ASCII_SP = 8'd32;

  localparam int LET_COUNT = 26;
  localparam int DIG_COUNT = 10;

  // A request's starting letter and digit must lie inside their classes.
  function automatic logic bases_ok(input logic [4:0] let_base, input logic [3:0] dig_base);
    return (let_base <= 5'(LET_COUNT - 1)) && (dig_base <= 4'(DIG_COUNT - 1));
  endfunction

endpackage

// File: rtl/id_emitter_mod_counter.sv
// Loadable modulo-MOD up-counter; o_next exposes the value it will hold after
// this edge so the owner can register outputs derived from it.
module mod_counter #(
  parameter int MOD   = 10,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_value,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = r_value;
    if (i_load)
      w_next = i_load_val;
    else if (i_inc)
      w_next = (r_value == WIDTH'(MOD - 1)) ? '0 : r_value + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_value <= '0;
    else
      r_value <= w_next;
  end

  assign o_value = r_value;
  assign o_next  = w_next;

endmodule

// File: rtl/id_emitter.sv
// Identifier stream source: emits letters, then digits, then an optional
// space, one registered byte per valid/ready handshake.
module id_emitter
  import id_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter bit TERM_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             upper,
  input  logic [4:0]       let_base,
  input  logic [LEN_W-1:0] let_len,
  input  logic [3:0]       dig_base,
  input  logic [LEN_W-1:0] dig_len,
  output logic [7:0]       o_char,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_let_rem, r_dig_rem;
  logic             r_upper;
  logic [7:0]       r_char;
  logic             r_valid, r_done, r_err;

  logic             w_fire, w_legal, w_accept, w_reject;
  logic             w_let_inc, w_dig_inc, w_upper_nxt;
  logic [4:0]       w_let_val, w_let_next;
  logic [3:0]       w_dig_val, w_dig_next;
  logic [7:0]       w_char_nxt;
  logic             w_valid_nxt, w_done_nxt, w_err_nxt;

  assign w_fire    = r_valid & ready;
  assign w_legal   = (let_len != '0) && bases_ok(let_base, dig_base);
  assign w_accept  = (r_state == S_IDLE) && start && w_legal;
  assign w_reject  = (r_state == S_IDLE) && start && !w_legal;
  assign w_let_inc = (r_state == S_LET) && w_fire;
  assign w_dig_inc = (r_state == S_DIG) && w_fire;

  mod_counter #(.MOD(LET_COUNT), .WIDTH(5)) u_let_ctr (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_accept),
    .i_load_val(let_base),
    .i_inc     (w_let_inc),
    .o_value   (w_let_val),
    .o_next    (w_let_next)
  );

  mod_counter #(.MOD(DIG_COUNT), .WIDTH(4)) u_dig_ctr (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_accept),
    .i_load_val(dig_base),
    .i_inc     (w_dig_inc),
    .o_value   (w_dig_val),
    .o_next    (w_dig_next)
  );

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Leaving a run happens when its count is 1, so the counts never wrap below 0.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_LET;
      S_LET: begin
        if (w_fire && (r_let_rem == LEN_W'(1))) begin
          if (r_dig_rem != '0) w_state_nxt = S_DIG;
          else if (TERM_EN)    w_state_nxt = S_TERM;
          else                 w_state_nxt = S_IDLE;
        end
      end
      S_DIG: begin
        if (w_fire && (r_dig_rem == LEN_W'(1)))
          w_state_nxt = TERM_EN ? S_TERM : S_IDLE;
      end
      S_TERM: if (w_fire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The byte for the next cycle is derived from the next state and counter values.
  always_comb begin
    w_upper_nxt = w_accept ? upper : r_upper;
    w_char_nxt  = 8'h00;
    unique case (w_state_nxt)
      S_LET:   w_char_nxt = (w_upper_nxt ? ASCII_UA : ASCII_LA) + {3'b000, w_let_next};
      S_DIG:   w_char_nxt = ASCII_0 + {4'b0000, w_dig_next};
      S_TERM:  w_char_nxt = ASCII_SP;
      default: w_char_nxt = 8'h00;
    endcase
    w_valid_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt  = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);
    w_err_nxt   = w_reject;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_let_rem <= '0;
      r_dig_rem <= '0;
      r_upper   <= 1'b0;
      r_char    <= 8'h00;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_let_rem <= let_len;
        r_dig_rem <= dig_len;
        r_upper   <= upper;
      end else begin
        if (w_let_inc) r_let_rem <= r_let_rem - LEN_W'(1);
        if (w_dig_inc) r_dig_rem <= r_dig_rem - LEN_W'(1);
      end
      r_char  <= w_char_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_char = r_char;
  assign valid  = r_valid;
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign err    = r_err;

endmodule

// File: tb/tb_id_emitter.sv
// Self-checking bench for id_emitter: a queue-based model of the expected byte
// stream is compared against the DUT every cycle, plus literal spot checks.
module tb_id_emitter;

  localparam int LEN_W   = 4;
  localparam bit TERM_EN = 1'b1;

  logic             clk = 1'b0;
  logic             reset, start, upper, ready;
  logic [4:0]       let_base;
  logic [LEN_W-1:0] let_len, dig_len;
  logic [3:0]       dig_base;
  logic [7:0]       o_char;
  logic             valid, busy, done, err;

  id_emitter #(.LEN_W(LEN_W), .TERM_EN(TERM_EN)) dut (
    .clk(clk), .reset(reset), .start(start), .upper(upper),
    .let_base(let_base), .let_len(let_len), .dig_base(dig_base), .dig_len(dig_len),
    .o_char(o_char), .valid(valid), .ready(ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] mq[$];
  logic [7:0] acc[$];
  logic       m_done = 1'b0;
  logic       m_err  = 1'b0;
  logic       m_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    logic       exp_v;
    logic [7:0] exp_c;
    exp_v = (mq.size() != 0);
    exp_c = exp_v ? mq[0] : 8'h00;
    chk("valid", 32'(valid), 32'(exp_v));
    chk("char",  32'(o_char), 32'(exp_c));
    chk("busy",  32'(busy),  32'(exp_v));
    chk("done",  32'(done),  32'(m_done));
    chk("err",   32'(err),   32'(m_err));
  endtask

  // Next-cycle expectation from the inputs the DUT samples at the coming edge.
  task automatic model_update();
    logic n_done, n_err_p;
    n_done  = 1'b0;
    n_err_p = 1'b0;
    if (reset) begin
      mq.delete();
      m_en = 1'b1;
    end else if (mq.size() != 0) begin
      if (ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) n_done = 1'b1;
      end
    end else if (start) begin
      if (int'(let_len) == 0 || int'(let_base) > 25 || int'(dig_base) > 9) begin
        n_err_p = 1'b1;
      end else begin
        for (int i = 0; i < int'(let_len); i++)
          mq.push_back(8'((upper ? 65 : 97) + ((int'(let_base) + i) % 26)));
        for (int i = 0; i < int'(dig_len); i++)
          mq.push_back(8'(48 + ((int'(dig_base) + i) % 10)));
        if (TERM_EN) mq.push_back(8'h20);
      end
    end
    m_done = n_done;
    m_err  = n_err_p;
  endtask

  task automatic step();
    @(negedge clk);
    if (m_en) begin
      cmp_cycle();
      if (valid && ready) acc.push_back(o_char);
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic up, input int lb, input int ll, input int db, input int dl);
    upper    = up;
    let_base = 5'(lb);
    let_len  = LEN_W'(ll);
    dig_base = 4'(db);
    dig_len  = LEN_W'(dl);
  endtask

  // Runs until the model stream is empty; random_rdy selects backpressure.
  task automatic drain(input bit random_rdy, input bit poke_start, output int cyc);
    cyc = 0;
    while (mq.size() != 0 && cyc < 300) begin
      ready = random_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (poke_start) begin
        start = ($urandom_range(0, 3) == 0);
        set_req(1'($urandom_range(0, 1)), $urandom_range(0, 25), $urandom_range(1, 15),
                $urandom_range(0, 9), $urandom_range(0, 15));
      end
      step();
      cyc++;
    end
    start = 1'b0;
    chk("drain_timeout", 32'(mq.size()), 32'd0);
  endtask

  logic [7:0] exp_basic[6] = '{8'h41, 8'h42, 8'h38, 8'h39, 8'h30, 8'h20};
  logic [7:0] exp_wrap[4]  = '{8'h79, 8'h7A, 8'h61, 8'h20};

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; ready = 1'b1;
    set_req(1'b0, 0, 1, 0, 0);
    step(); step();
    reset = 1'b0;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_char",  32'(o_char), 32'd0);
    step();

    // Basic stream with ready held high.
    acc.delete();
    set_req(1'b1, 0, 2, 8, 3); start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    chk("basic_first_valid", 32'(valid), 32'd1);
    drain(1'b0, 1'b0, cyc);
    chk("basic_cycles", 32'(cyc), 32'd6);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_busy", 32'(busy), 32'd0);
    chk("basic_len", 32'(acc.size()), 32'd6);
    for (int i = 0; i < 6 && i < acc.size(); i++) chk("basic_byte", 32'(acc[i]), 32'(exp_basic[i]));
    step();

    // Letter wrap, no digits.
    acc.delete();
    set_req(1'b0, 24, 3, 0, 0); start = 1'b1;
    step();
    start = 1'b0;
    drain(1'b0, 1'b0, cyc);
    chk("wrap_len", 32'(acc.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc.size(); i++) chk("wrap_byte", 32'(acc[i]), 32'(exp_wrap[i]));
    step();

    // Backpressure on the basic stream.
    for (int rep = 0; rep < 3; rep++) begin
      acc.delete();
      set_req(1'b1, 0, 2, 8, 3); start = 1'b1;
      step();
      start = 1'b0;
      drain(1'b1, 1'b0, cyc);
      chk("bp_len", 32'(acc.size()), 32'd6);
      for (int i = 0; i < 6 && i < acc.size(); i++) chk("bp_byte", 32'(acc[i]), 32'(exp_basic[i]));
      ready = 1'b1;
      step();
    end

    // Illegal requests, then a legal one.
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: set_req(1'b1, 0, 0, 0, 1);
        1: set_req(1'b1, 26, 2, 0, 1);
        default: set_req(1'b1, 0, 2, 10, 1);
      endcase
      start = 1'b1;
      step();
      start = 1'b0;
      chk("illegal_err", 32'(err), 32'd1);
      chk("illegal_valid", 32'(valid), 32'd0);
      step();
    end
    acc.delete();
    set_req(1'b1, 0, 2, 8, 3); start = 1'b1;
    step();
    start = 1'b0;
    drain(1'b0, 1'b0, cyc);
    chk("post_illegal_len", 32'(acc.size()), 32'd6);

    // Start in the done cycle is accepted; start while busy is ignored.
    set_req(1'b1, 0, 2, 8, 3); start = 1'b1;
    step();
    start = 1'b0;
    drain(1'b0, 1'b1, cyc);
    set_req(1'b0, 3, 1, 1, 1); start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_valid", 32'(valid), 32'd1);
    chk("b2b_char",  32'(o_char), 32'h64);
    drain(1'b0, 1'b0, cyc);
    step();

    // Reset after the second fire, then a fresh request.
    set_req(1'b1, 0, 2, 8, 3); start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_char",  32'(o_char), 32'd0);
    chk("midrst_done",  32'(done), 32'd0);
    acc.delete();
    set_req(1'b1, 5, 1, 0, 0); start = 1'b1;
    step();
    start = 1'b0;
    drain(1'b0, 1'b0, cyc);
    chk("midrst_first", (acc.size() != 0) ? 32'(acc[0]) : 32'hFFFF, 32'h46);
    step();

    // Randomized requests with backpressure and busy-time start pokes.
    for (int n = 0; n < 30; n++) begin
      set_req(1'($urandom_range(0, 1)), $urandom_range(0, 27), $urandom_range(0, 15),
              $urandom_range(0, 11), $urandom_range(0, 15));
      start = 1'b1;
      ready = ($urandom_range(0, 1) == 1);
      step();
      start = 1'b0;
      drain(1'b1, 1'b1, cyc);
      ready = 1'b1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/id_emitter.md
# id_emitter

Character-stream generator for the identifier path: on a start request it emits a well-formed identifier, a run of letters followed by a run of digits, then an optional space terminator, one ASCII byte per handshake. It sits upstream of the identifier recognizer FSM and drives its `char` input, both as a test-pattern source and as the transmit end of the identifier stream. Its output obeys the same letter/digit classes the recognizer checks.

## Interface
- `LEN_W`, 4: width of the run-length fields; max run = 2^LEN_W−1.
- `TERM_EN`, 1: when 1, a space (8'h20) terminator follows the last character.
- `clk` input 1: single clock, all state updates on posedge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request pulse; sampled only in IDLE.
- `upper` input 1: 1 selects letters 'A'..'Z'; 0 selects 'a'..'z'.
- `let_base` input 5: first letter index, 0..25.
- `let_len` input LEN_W: letter count; must be ≥1.
- `dig_base` input 4: first digit value, 0..9.
- `dig_len` input LEN_W: digit count; 0 is legal.
- `char` output 8: current ASCII byte.
- `valid` output 1: `char` is valid.
- `ready` input 1: downstream accepts; fire = `valid & ready`.
- `busy` output 1: request in progress (state ≠ IDLE).
- `done` output 1: one-cycle pulse after the final fire.
- `err` output 1: one-cycle pulse on a rejected request.

## Operation
- States: IDLE, LET, DIG, TERM. Request fields are captured on accept and ignored afterwards.
- IDLE:
  - If `start` is high and the args are illegal (`let_len`=0, `let_base`>25 or `dig_base`>9): pulse `err` next cycle and stay in IDLE.
  - If `start` is high and the args are legal: go to LET and load letter index = `let_base`, digit value = `dig_base`, and both remaining counts.
- LET: `char` = base ('A'=65 or 'a'=97) + index. On fire:
  - Index increments mod 26, so 'Z' wraps to 'A'.
  - Remaining count decrements.
  - On the last letter, go to DIG if `dig_len`≠0, else to TERM if `TERM_EN`, else finish.
- DIG: `char` = 48 + value. On fire:
  - Value increments mod 10, so '9' wraps to '0'.
  - On the last digit, go to TERM if `TERM_EN`, else finish.
- TERM: `char` = 8'h20. On fire, finish.
- Finish: return to IDLE and pulse `done` for exactly one cycle.
- Stream content guarantee: a downstream recognizer ends the identifier in its digit state iff `dig_len`≥1, and the terminator returns it to its idle state.
- Counter arithmetic: run counters are LEN_W bits and never underflow, because the state changes when the count reaches 1.
- `start` while `busy` is ignored; it is neither queued nor flagged.

## Timing
- Reset values: state IDLE, `char`=8'h00, `valid`=0, `busy`=0, `done`=0, `err`=0, all counters 0.
- Reset takes effect mid-stream: the next cycle has `valid`=0, no `done` and no `err`.
- Latency: `start` accepted at edge N gives `valid`=1 with the first letter in cycle N+1. `err` is likewise asserted in cycle N+1.
- `char` and `valid` are registered. While `valid & !ready`, both hold stable.
- `valid` stays high across characters when `ready` is held high, giving one byte per cycle.
- Final fire at edge M gives `valid`=0, `busy`=0 and `done`=1 in cycle M+1.
- A `start` sampled in that same cycle (`done`=1) is accepted, so back-to-back identifiers have a 1-cycle gap.
- Total cycles with `ready`=1: `let_len` + `dig_len` + `TERM_EN`.

## Structure
- Shared package `id_pkg` holds:
  - State encoding (2 bits).
  - ASCII constants: 'A'=65, 'a'=97, '0'=48, space=32.
  - Class bounds, shared with the recognizer.
- Sub-module `mod_counter` (parameters MOD and WIDTH, with load/inc/value) is instantiated twice: MOD=26 for letters and MOD=10 for digits.
- The FSM, handshake and output register live in `id_emitter`.

## Test plan
- Basic stream: upper=1, let_base=0, let_len=2, dig_base=8, dig_len=3, `ready`=1 → 41,42,38,39,30,20 on consecutive cycles, then `done` pulse, `busy` low.
- Letter wrap, no digits: upper=0, let_base=24, let_len=3, dig_len=0 → 79,7A,61,20, then `done`. Check the recognizer output stays 0 throughout.
- Backpressure: toggle `ready` pseudo-randomly during the basic stream → the accepted sequence is identical and `char` is stable whenever `valid & !ready`.
- Illegal requests: let_len=0, then let_base=26, then dig_base=10 → each gives an `err` pulse 1 cycle later with no `valid`. A legal `start` afterwards works normally.
- Collision: `start` while busy is ignored. `start` in the `done` cycle gives the first letter in the next cycle.
- Reset mid-stream: assert `reset` after the 2nd fire → next cycle `valid`=0, `char`=00, no `done`. A new request then starts from its own `let_base`.
